// File: rtl/core_pkg.sv
// Shared definitions for the Ludi-V core pipeline.
//   - funct3 encodings for RV32I load/store access size and sign
//   - mem_state_t : state of the memory stage bus sequencer
//   - access_misaligned() : alignment / legality check for a load or store
package core_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } mem_state_t;

  // Returns 1 when the access cannot go to the bus: halfwords must be
  // 2-byte aligned, words 4-byte aligned. Encodings 011/110/111 have no
  // RV32I meaning and are rejected the same way.
  function automatic logic access_misaligned(input logic [2:0] funct3,
                                             input logic [1:0] offset);
    logic bad;
    case (funct3)
      F3_B, F3_BU: bad = 1'b0;
      F3_H, F3_HU: bad = offset[0];
      F3_W:        bad = (offset != 2'b00);
      default:     bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load data alignment and extension.
//   rdata  : 32-bit word returned by the data bus
//   offset : byte offset of the access within the word (addr[1:0])
//   funct3 : RV32I load size/sign encoding
//   result : selected lane, sign- or zero-extended to 32 bits
module load_align
  import core_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [31:0] lane;

  // Shift the addressed byte/halfword down to bit 0.
  assign lane = rdata >> {offset, 3'b000};

  always_comb begin
    case (funct3)
      F3_B:    result = {{24{lane[7]}}, lane[7:0]};
      F3_H:    result = {{16{lane[15]}}, lane[15:0]};
      F3_BU:   result = {24'h000000, lane[7:0]};
      F3_HU:   result = {16'h0000, lane[15:0]};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/stage_memory.sv
// Ludi-V memory stage. Takes the registered execute outputs, performs
// RV32I loads/stores over a req/gnt/rvalid bus and presents a registered
// result to writeback. Upstream is stalled while a bus access is open.
//   execute_*      : instruction from execute (sampled only in IDLE)
//   stall          : upstream must hold its outputs
//   dmem_*         : data memory request/response channel
//   memory_*       : registered writeback result, memory_valid pulses once
//   misaligned_err : pulses for a misaligned or illegal access
//   bus_err        : pulses when gnt/rvalid did not arrive in time
module stage_memory
  import core_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        execute_valid,
  input  logic [31:0] execute_alu_result,
  input  logic [4:0]  execute_rd,
  input  logic        execute_wr_enable,
  input  logic        execute_mem_to_reg,
  input  logic        execute_mem_write,
  input  logic [31:0] execute_store_data,
  input  logic [2:0]  execute_funct3,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        memory_valid,
  output logic [4:0]  memory_rd,
  output logic        memory_wr_enable,
  output logic [31:0] memory_result,
  output logic        misaligned_err,
  output logic        bus_err
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  // The abort fires in the cycle the counter holds its last value, so the
  // sequencer spends exactly TIMEOUT_CYCLES cycles in REQ or WAIT.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  mem_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       addr_q, addr_d;
  logic [2:0]        funct3_q, funct3_d;
  logic              we_q, we_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [4:0]        rd_q, rd_d;
  logic              wr_en_q, wr_en_d;
  logic              memory_valid_q, memory_valid_d;
  logic [4:0]        memory_rd_q, memory_rd_d;
  logic              memory_wr_enable_q, memory_wr_enable_d;
  logic [31:0]       memory_result_q, memory_result_d;
  logic              misaligned_err_q, misaligned_err_d;
  logic              bus_err_q, bus_err_d;

  logic [31:0] load_data;
  logic [3:0]  acc_be;
  logic [31:0] acc_wdata;
  logic        acc_bad;
  logic        timeout_hit;

  load_align u_load_align (
    .rdata  (dmem_rdata),
    .offset (addr_q[1:0]),
    .funct3 (funct3_q),
    .result (load_data)
  );

  // Lane placement for the incoming access; only funct3[1:0] selects size.
  always_comb begin
    case (execute_funct3[1:0])
      2'b00: begin
        acc_be    = 4'b0001 << execute_alu_result[1:0];
        acc_wdata = {4{execute_store_data[7:0]}};
      end
      2'b01: begin
        acc_be    = execute_alu_result[1] ? 4'b1100 : 4'b0011;
        acc_wdata = {2{execute_store_data[15:0]}};
      end
      default: begin
        acc_be    = 4'b1111;
        acc_wdata = execute_store_data;
      end
    endcase
  end

  assign acc_bad     = access_misaligned(execute_funct3, execute_alu_result[1:0]);
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

  always_comb begin
    state_d            = state_q;
    cnt_d              = cnt_q;
    addr_d             = addr_q;
    funct3_d           = funct3_q;
    we_d               = we_q;
    be_d               = be_q;
    wdata_d            = wdata_q;
    rd_d               = rd_q;
    wr_en_d            = wr_en_q;
    memory_valid_d     = 1'b0;
    memory_rd_d        = memory_rd_q;
    memory_wr_enable_d = 1'b0;
    memory_result_d    = memory_result_q;
    misaligned_err_d   = 1'b0;
    bus_err_d          = 1'b0;

    case (state_q)
      IDLE: begin
        if (execute_valid) begin
          if (execute_mem_to_reg || execute_mem_write) begin
            if (acc_bad) begin
              // Faulting access retires immediately without touching the bus.
              memory_valid_d   = 1'b1;
              memory_rd_d      = execute_rd;
              memory_result_d  = 32'h0;
              misaligned_err_d = 1'b1;
            end else begin
              state_d  = REQ;
              cnt_d    = '0;
              addr_d   = execute_alu_result;
              funct3_d = execute_funct3;
              we_d     = execute_mem_write;
              be_d     = acc_be;
              wdata_d  = acc_wdata;
              rd_d     = execute_rd;
              wr_en_d  = execute_wr_enable;
            end
          end else begin
            memory_valid_d     = 1'b1;
            memory_rd_d        = execute_rd;
            memory_wr_enable_d = execute_wr_enable;
            memory_result_d    = execute_alu_result;
          end
        end
      end

      REQ: begin
        if (dmem_gnt) begin
          if (we_q) begin
            state_d         = IDLE;
            memory_valid_d  = 1'b1;
            memory_rd_d     = rd_q;
            memory_result_d = 32'h0;
          end else begin
            state_d = WAIT;
            cnt_d   = '0;
          end
        end else if (timeout_hit) begin
          state_d         = IDLE;
          memory_valid_d  = 1'b1;
          memory_rd_d     = rd_q;
          memory_result_d = 32'h0;
          bus_err_d       = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      WAIT: begin
        if (dmem_rvalid) begin
          state_d            = IDLE;
          memory_valid_d     = 1'b1;
          memory_rd_d        = rd_q;
          memory_wr_enable_d = wr_en_q;
          memory_result_d    = load_data;
        end else if (timeout_hit) begin
          state_d         = IDLE;
          memory_valid_d  = 1'b1;
          memory_rd_d     = rd_q;
          memory_result_d = 32'h0;
          bus_err_d       = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q            <= IDLE;
      cnt_q              <= '0;
      addr_q             <= 32'h0;
      funct3_q           <= 3'b000;
      we_q               <= 1'b0;
      be_q               <= 4'b0000;
      wdata_q            <= 32'h0;
      rd_q               <= 5'd0;
      wr_en_q            <= 1'b0;
      memory_valid_q     <= 1'b0;
      memory_rd_q        <= 5'd0;
      memory_wr_enable_q <= 1'b0;
      memory_result_q    <= 32'h0;
      misaligned_err_q   <= 1'b0;
      bus_err_q          <= 1'b0;
    end else begin
      state_q            <= state_d;
      cnt_q              <= cnt_d;
      addr_q             <= addr_d;
      funct3_q           <= funct3_d;
      we_q               <= we_d;
      be_q               <= be_d;
      wdata_q            <= wdata_d;
      rd_q               <= rd_d;
      wr_en_q            <= wr_en_d;
      memory_valid_q     <= memory_valid_d;
      memory_rd_q        <= memory_rd_d;
      memory_wr_enable_q <= memory_wr_enable_d;
      memory_result_q    <= memory_result_d;
      misaligned_err_q   <= misaligned_err_d;
      bus_err_q          <= bus_err_d;
    end
  end

  assign stall            = (state_q != IDLE);
  assign dmem_req         = (state_q == REQ);
  assign dmem_we          = we_q;
  assign dmem_addr        = {addr_q[31:2], 2'b00};
  assign dmem_be          = be_q;
  assign dmem_wdata       = wdata_q;
  assign memory_valid     = memory_valid_q;
  assign memory_rd        = memory_rd_q;
  assign memory_wr_enable = memory_wr_enable_q;
  assign memory_result    = memory_result_q;
  assign misaligned_err   = misaligned_err_q;
  assign bus_err          = bus_err_q;

endmodule

// File: tb/tb_stage_memory.sv
// Randomized self-checking bench for stage_memory. A byte-addressed
// memory model and RV32I size/sign rules produce all expected values.
module tb_stage_memory;
  import core_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        execute_valid;
  logic [31:0] execute_alu_result;
  logic [4:0]  execute_rd;
  logic        execute_wr_enable;
  logic        execute_mem_to_reg;
  logic        execute_mem_write;
  logic [31:0] execute_store_data;
  logic [2:0]  execute_funct3;
  logic        stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        memory_valid;
  logic [4:0]  memory_rd;
  logic        memory_wr_enable;
  logic [31:0] memory_result;
  logic        misaligned_err;
  logic        bus_err;

  int checks   = 0;
  int failures = 0;

  bit [7:0] mem [int unsigned];

  always #5 clk = ~clk;

  stage_memory #(.TIMEOUT_CYCLES(4)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .execute_valid      (execute_valid),
    .execute_alu_result (execute_alu_result),
    .execute_rd         (execute_rd),
    .execute_wr_enable  (execute_wr_enable),
    .execute_mem_to_reg (execute_mem_to_reg),
    .execute_mem_write  (execute_mem_write),
    .execute_store_data (execute_store_data),
    .execute_funct3     (execute_funct3),
    .stall              (stall),
    .dmem_req           (dmem_req),
    .dmem_we            (dmem_we),
    .dmem_addr          (dmem_addr),
    .dmem_be            (dmem_be),
    .dmem_wdata         (dmem_wdata),
    .dmem_gnt           (dmem_gnt),
    .dmem_rvalid        (dmem_rvalid),
    .dmem_rdata         (dmem_rdata),
    .memory_valid       (memory_valid),
    .memory_rd          (memory_rd),
    .memory_wr_enable   (memory_wr_enable),
    .memory_result      (memory_result),
    .misaligned_err     (misaligned_err),
    .bus_err            (bus_err)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit [7:0] rd_byte(input int unsigned a);
    if (!mem.exists(a)) mem[a] = 8'($urandom);
    return mem[a];
  endfunction

  function automatic int size_of(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 0;
    endcase
  endfunction

  function automatic bit is_faulty(input logic [31:0] addr, input logic [2:0] f3);
    int sz = size_of(f3);
    return (sz == 0) || ((addr % sz) != 0);
  endfunction

  function automatic logic [31:0] word_at(input logic [31:0] addr);
    int unsigned base = addr & 32'hFFFF_FFFC;
    return {rd_byte(base + 3), rd_byte(base + 2), rd_byte(base + 1), rd_byte(base)};
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [2:0] f3);
    int sz = size_of(f3);
    longint unsigned v = 0;
    for (int k = 0; k < sz; k++) v = v | (longint'(rd_byte(addr + k)) << (8 * k));
    if (f3 == 3'b000 && v >= 128)   v = v + 64'hFFFF_FF00;
    if (f3 == 3'b001 && v >= 32768) v = v + 64'hFFFF_0000;
    return 32'(v);
  endfunction

  task automatic model_store(input logic [31:0] addr, input logic [2:0] f3, input logic [31:0] data);
    for (int k = 0; k < size_of(f3); k++) mem[addr + k] = data[8*k +: 8];
  endtask

  function automatic logic [3:0] exp_be(input logic [31:0] addr, input logic [2:0] f3);
    logic [3:0] be = 4'b0000;
    for (int k = 0; k < size_of(f3); k++) be[(addr % 4) + k] = 1'b1;
    return be;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] data);
    logic [31:0] w;
    int sz = size_of(f3);
    for (int i = 0; i < 4; i++) w[8*i +: 8] = data[8*(i % sz) +: 8];
    return w;
  endfunction

  // ---------------- stimulus ----------------
  task automatic drive_idle();
    execute_valid      = 1'b0;
    execute_mem_to_reg = 1'b0;
    execute_mem_write  = 1'b0;
  endtask

  // Runs one instruction starting at a negedge with the DUT idle. With
  // chain set, an ALU op is held upstream for the whole transaction and
  // must retire on the cycle right after.
  task automatic run_op(input bit ld, input bit st, input logic [31:0] a, input logic [31:0] sd,
                        input logic [2:0] f3, input logic [4:0] rd, input bit we,
                        input int gd, input int rvd, input bit chain);
    logic [31:0] c_alu = $urandom;
    logic [4:0]  c_rd  = 5'($urandom);
    logic [31:0] word, exp;
    execute_valid = 1'b1; execute_alu_result = a; execute_rd = rd; execute_wr_enable = we;
    execute_mem_to_reg = ld; execute_mem_write = st; execute_store_data = sd; execute_funct3 = f3;
    @(negedge clk);
    if (chain) begin
      execute_alu_result = c_alu; execute_rd = c_rd; execute_wr_enable = 1'b1;
      execute_mem_to_reg = 1'b0; execute_mem_write = 1'b0;
    end else drive_idle();
    $display("op ld=%0d st=%0d addr=0x%08h f3=%0d rd=%0d gd=%0d rvd=%0d chain=%0d",
             ld, st, a, f3, rd, gd, rvd, chain);
    if (!ld && !st) begin
      check_val("alu_valid", 32'(memory_valid), 32'd1);
      check_val("alu_result", memory_result, a);
      check_val("alu_rd", 32'(memory_rd), 32'(rd));
      check_val("alu_wr", 32'(memory_wr_enable), 32'(we));
      check_val("alu_stall", 32'(stall), 32'd0);
    end else if (is_faulty(a, f3)) begin
      check_val("mis_valid", 32'(memory_valid), 32'd1);
      check_val("mis_err", 32'(misaligned_err), 32'd1);
      check_val("mis_wr", 32'(memory_wr_enable), 32'd0);
      check_val("mis_req", 32'(dmem_req), 32'd0);
      check_val("mis_stall", 32'(stall), 32'd0);
    end else begin
      for (int c = 0; c <= gd; c++) begin
        check_val("req_req", 32'(dmem_req), 32'd1);
        check_val("req_stall", 32'(stall), 32'd1);
        check_val("req_valid", 32'(memory_valid), 32'd0);
        check_val("req_addr", dmem_addr, a & 32'hFFFF_FFFC);
        check_val("req_we", 32'(dmem_we), 32'(st));
        if (st) begin
          check_val("req_be", 32'(dmem_be), 32'(exp_be(a, f3)));
          check_val("req_wdata", dmem_wdata, exp_wdata(f3, sd));
        end
        if (c == gd) dmem_gnt = 1'b1;
        @(negedge clk);
        dmem_gnt = 1'b0;
      end
      if (st) begin
        model_store(a, f3, sd);
        check_val("st_valid", 32'(memory_valid), 32'd1);
        check_val("st_wr", 32'(memory_wr_enable), 32'd0);
        check_val("st_rd", 32'(memory_rd), 32'(rd));
        check_val("st_stall", 32'(stall), 32'd0);
      end else begin
        word = word_at(a);
        exp  = model_load(a, f3);
        for (int c = 0; c <= rvd; c++) begin
          check_val("wait_stall", 32'(stall), 32'd1);
          check_val("wait_req", 32'(dmem_req), 32'd0);
          check_val("wait_valid", 32'(memory_valid), 32'd0);
          if (c == rvd) begin dmem_rvalid = 1'b1; dmem_rdata = word; end
          @(negedge clk);
          dmem_rvalid = 1'b0; dmem_rdata = $urandom;
        end
        check_val("ld_valid", 32'(memory_valid), 32'd1);
        check_val("ld_result", memory_result, exp);
        check_val("ld_wr", 32'(memory_wr_enable), 32'(we));
        check_val("ld_rd", 32'(memory_rd), 32'(rd));
        check_val("ld_stall", 32'(stall), 32'd0);
      end
    end
    if (chain) begin
      @(negedge clk);
      drive_idle();
      check_val("chain_valid", 32'(memory_valid), 32'd1);
      check_val("chain_result", memory_result, c_alu);
      check_val("chain_rd", 32'(memory_rd), 32'(c_rd));
    end
  endtask

  // Word load with no response (or gnt but no rvalid): must abort after
  // exactly four cycles in the stuck phase.
  task automatic timeout_case(input bit gnt_first);
    int n = 0;
    execute_valid = 1'b1; execute_alu_result = 32'h0000_4000; execute_rd = 5'd9;
    execute_wr_enable = 1'b1; execute_mem_to_reg = 1'b1; execute_mem_write = 1'b0;
    execute_funct3 = F3_W;
    @(negedge clk);
    drive_idle();
    if (gnt_first) begin
      dmem_gnt = 1'b1;
      @(negedge clk);
      dmem_gnt = 1'b0;
    end
    while (memory_valid !== 1'b1 && n < 20) begin
      n++;
      @(negedge clk);
    end
    $display("timeout gnt_first=%0d busy_cycles=%0d", gnt_first, n);
    check_val("to_cycles", 32'(n), 32'd4);
    check_val("to_bus_err", 32'(bus_err), 32'd1);
    check_val("to_wr", 32'(memory_wr_enable), 32'd0);
    check_val("to_stall", 32'(stall), 32'd0);
    check_val("to_req", 32'(dmem_req), 32'd0);
  endtask

  initial begin
    logic [2:0]  f3;
    logic [31:0] a;
    bit ld, st;
    int sz;
    rst_n = 1'b0;
    drive_idle();
    execute_alu_result = 32'h0; execute_rd = 5'd0; execute_wr_enable = 1'b0;
    execute_store_data = 32'h0; execute_funct3 = 3'b000;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
    repeat (2) @(negedge clk);
    check_val("rst_stall", 32'(stall), 32'd0);
    check_val("rst_req", 32'(dmem_req), 32'd0);
    check_val("rst_valid", 32'(memory_valid), 32'd0);
    check_val("rst_errs", 32'({misaligned_err, bus_err}), 32'd0);
    check_val("rst_result", memory_result, 32'd0);
    rst_n = 1'b1;

    // Directed cases
    run_op(1'b0, 1'b0, 32'h0000_1234, 32'h0, 3'b000, 5'd5, 1'b1, 0, 0, 1'b0);
    run_op(1'b0, 1'b1, 32'h0000_1003, 32'hAABB_CCDD, F3_B, 5'd0, 1'b0, 2, 0, 1'b0);
    mem[32'h2000] = 8'h00; mem[32'h2001] = 8'h00; mem[32'h2002] = 8'h80; mem[32'h2003] = 8'h00;
    run_op(1'b1, 1'b0, 32'h0000_2002, 32'h0, F3_B, 5'd7, 1'b1, 0, 3, 1'b0);
    check_val("lb_literal", memory_result, 32'hFFFF_FF80);
    run_op(1'b1, 1'b0, 32'h0000_2002, 32'h0, F3_BU, 5'd8, 1'b1, 1, 3, 1'b0);
    check_val("lbu_literal", memory_result, 32'h0000_0080);
    run_op(1'b1, 1'b0, 32'h0000_3002, 32'h0, F3_W, 5'd3, 1'b1, 0, 0, 1'b1);
    timeout_case(1'b1);
    timeout_case(1'b0);

    // Reset in the middle of a load
    execute_valid = 1'b1; execute_alu_result = 32'h0000_5002; execute_rd = 5'd4;
    execute_wr_enable = 1'b1; execute_mem_to_reg = 1'b1; execute_funct3 = F3_H;
    @(negedge clk);
    drive_idle();
    dmem_gnt = 1'b1;
    @(negedge clk);
    dmem_gnt = 1'b0;
    check_val("pre_rst_stall", 32'(stall), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    $display("async reset mid-load");
    check_val("arst_stall", 32'(stall), 32'd0);
    check_val("arst_req", 32'(dmem_req), 32'd0);
    check_val("arst_valid", 32'(memory_valid), 32'd0);
    check_val("arst_addr", dmem_addr, 32'd0);
    check_val("arst_result", memory_result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("post_rst_valid", 32'(memory_valid), 32'd0);
    run_op(1'b0, 1'b0, 32'hCAFE_F00D, 32'h0, 3'b000, 5'd12, 1'b1, 0, 0, 1'b0);

    // Randomized mix over a small address window so loads see stores
    for (int i = 0; i < 80; i++) begin
      int kind = $urandom_range(0, 2);
      ld = (kind == 1);
      st = (kind == 2);
      if ($urandom_range(0, 9) == 0) f3 = ($urandom_range(0, 1) == 0) ? 3'b011 : 3'b111;
      else if (ld) f3 = 3'($urandom_range(0, 4)) + ((kind == 1 && $urandom_range(0, 1) == 1) ? 3'd0 : 3'd0);
      else f3 = 3'($urandom_range(0, 2));
      if (ld && f3 == 3'b011) f3 = 3'b100;
      if (ld && $urandom_range(0, 3) == 0) f3 = F3_HU;
      a = 32'h0000_8000 + 32'($urandom_range(0, 31));
      sz = size_of(f3);
      if (sz != 0 && $urandom_range(0, 9) < 7) a = a - (a % sz);
      if (kind == 0) a = $urandom;
      run_op(ld, st, a, $urandom, f3, 5'($urandom), 1'($urandom),
             $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
